// File: rtl/reflet_float_div_seq_pkg.sv
// Shared definitions for the sequential float divider:
// format widths per float_size and FSM state encoding.
package reflet_float_div_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_SPECIAL,
    S_DONE
  } state_t;

  function automatic int exp_w(input int fs);
    return (fs == 16) ? 5 : 8;
  endfunction

  function automatic int mant_w(input int fs);
    return (fs == 16) ? 10 : 23;
  endfunction

  function automatic int bias(input int fs);
    return (1 << (exp_w(fs) - 1)) - 1;
  endfunction

endpackage

// File: rtl/reflet_float_div_seq_mdiv.sv
// Restoring significand divider, one quotient bit per step.
// Kept generic so a square-root unit can reuse it.
module reflet_float_div_seq_mdiv #(
  parameter int W     = 24,
  parameter int ITERS = 25,
  parameter int CW    = $clog2(ITERS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     num,
  input  logic [W-1:0]     den,
  output logic             finished,
  output logic [ITERS-1:0] quo
);

  logic [W:0]    rem;
  logic [W-1:0]  dreg;
  logic [CW-1:0] cnt;
  logic          ge;
  logic [W:0]    nxt;

  assign ge  = rem >= {1'b0, dreg};
  assign nxt = ge ? rem - {1'b0, dreg} : rem;

  // high during the step that produces the last quotient bit
  assign finished = step && (cnt == CW'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem  <= '0;
      dreg <= '0;
      quo  <= '0;
      cnt  <= '0;
    end else if (load) begin
      rem  <= {1'b0, num};
      dreg <= den;
      quo  <= '0;
      cnt  <= '0;
    end else if (step) begin
      rem  <= nxt << 1;
      quo  <= {quo[ITERS-2:0], ge};
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reflet_float_div_seq.sv
// Iterative IEEE-754 divider: quotient = in1 / in2,
// truncating, denormals flushed, start/busy/done handshake.
module reflet_float_div_seq
  import reflet_float_div_seq_pkg::*;
#(
  parameter int float_size = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [float_size-1:0] in1,
  input  logic [float_size-1:0] in2,
  output logic                  busy,
  output logic                  done,
  output logic [float_size-1:0] quotient
);

  localparam int FS   = float_size;
  localparam int EW   = exp_w(FS);
  localparam int MW   = mant_w(FS);
  localparam int BIAS = bias(FS);
  localparam int XW   = EW + 2;
  localparam int QW   = MW + 2;

  localparam logic [FS-1:0] QNAN =
    {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [FS-1:0] INF =
    {1'b0, {EW{1'b1}}, {MW{1'b0}}};

  state_t state, nxt;

  logic [FS-1:0] a_r, b_r, q_r;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic          sgn;
  logic          a_zero, a_inf, a_nan;
  logic          b_zero, b_inf, b_nan;
  logic          is_spec;
  logic [FS-1:0] spec_res, norm_res;
  logic          ld, stp, fin;
  logic [QW-1:0] qv;
  logic          adj;
  logic [XW-1:0] e_u;
  logic [MW-1:0] mant;
  logic          ovf, unf;

  assign ea  = a_r[FS-2:MW];
  assign eb  = b_r[FS-2:MW];
  assign fa  = a_r[MW-1:0];
  assign fb  = b_r[MW-1:0];
  assign sgn = a_r[FS-1] ^ b_r[FS-1];

  // exponent 0 covers denormals, which are treated as zero
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  assign is_spec = a_zero | a_inf | a_nan
                 | b_zero | b_inf | b_nan;

  always_comb begin
    spec_res = {sgn, {(FS-1){1'b0}}};
    if (a_nan || b_nan
        || (a_zero && b_zero)
        || (a_inf && b_inf))
      spec_res = QNAN;
    else if (b_zero || a_inf)
      spec_res = {sgn, INF[FS-2:0]};
  end

  reflet_float_div_seq_mdiv #(
    .W    (MW + 1),
    .ITERS(QW)
  ) u_mdiv (
    .clk     (clk),
    .reset   (reset),
    .load    (ld),
    .step    (stp),
    .num     ({1'b1, fa}),
    .den     ({1'b1, fb}),
    .finished(fin),
    .quo     (qv)
  );

  // quotient lies in (0.5, 2): at most one left shift needed
  assign adj  = ~qv[QW-1];
  assign mant = qv[QW-1] ? qv[QW-2:1] : qv[QW-3:0];
  assign e_u  = {2'b00, ea} - {2'b00, eb}
              + XW'(BIAS) - XW'(adj);
  assign ovf  = !e_u[XW-1]
              && (e_u >= XW'((1 << EW) - 1));
  assign unf  = e_u[XW-1] || (e_u == '0);

  always_comb begin
    norm_res = {sgn, e_u[EW-1:0], mant};
    if (ovf)
      norm_res = {sgn, INF[FS-2:0]};
    else if (unf)
      norm_res = {sgn, {(FS-1){1'b0}}};
  end

  always_comb begin
    nxt = state;
    ld  = 1'b0;
    stp = 1'b0;
    unique case (state)
      S_IDLE: if (start) nxt = S_UNPACK;
      S_UNPACK: begin
        if (is_spec) begin
          nxt = S_SPECIAL;
        end else begin
          nxt = S_DIVIDE;
          ld  = 1'b1;
        end
      end
      S_DIVIDE: begin
        stp = 1'b1;
        if (fin) nxt = S_NORM;
      end
      S_NORM:    nxt = S_DONE;
      S_SPECIAL: nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      q_r   <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        a_r <= in1;
        b_r <= in2;
      end
      if (state == S_NORM)    q_r <= norm_res;
      if (state == S_SPECIAL) q_r <= spec_res;
    end
  end

  assign busy = (state == S_UNPACK) || (state == S_DIVIDE)
             || (state == S_NORM)   || (state == S_SPECIAL);
  assign done     = (state == S_DONE);
  assign quotient = q_r;

endmodule

// File: tb/tb_reflet_float_div_seq.sv
// Self-checking bench for reflet_float_div_seq (32-bit):
// directed cases, handshake corners and random ops vs a model.
module tb_reflet_float_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy, done;
  logic [31:0] quotient;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  reflet_float_div_seq #(.float_size(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .quotient(quotient)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: {is_special, result}, using integer long division
  function automatic logic [32:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b);
    int     xa, xb, e;
    longint ma, mb, m;
    logic   s, az, bz, ai, bi, an, bn;
    xa = int'(a[30:23]);
    xb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (xa == 0);
    bz = (xb == 0);
    ai = (xa == 255) && (a[22:0] == 0);
    bi = (xb == 255) && (b[22:0] == 0);
    an = (xa == 255) && (a[22:0] != 0);
    bn = (xb == 255) && (b[22:0] != 0);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 32'h7FC00000};
    if (bz || ai) return {1'b1, s, 31'h7F800000};
    if (az || bi) return {1'b1, s, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = xa - xb + 127;
    if (ma >= mb) m = (ma << 23) / mb;
    else begin
      m = (ma << 24) / mb;
      e = e - 1;
    end
    if (e >= 255) return {1'b0, s, 31'h7F800000};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], m[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat,
                       output bit busy_ok);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1 = $urandom; in2 = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    r = quotient;
  endtask

  task automatic run_chk(input string tag, input logic [31:0] a,
                         input logic [31:0] b);
    logic [32:0] exp;
    logic [31:0] r;
    int          lat;
    bit          bok;
    exp = ref_div(a, b);
    do_op(a, b, r, lat, bok);
    check({tag, "_q"}, r, exp[31:0]);
    check({tag, "_lat"}, 32'(lat), exp[32] ? 32'd3 : 32'd28);
    check({tag, "_busy"}, {31'b0, bok}, 32'd1);
  endtask

  initial begin
    logic [31:0] r, a, b;
    int          lat, seen;
    bit          bok;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", quotient, 32'h0);
    reset = 1'b1;

    do_op(32'h40C00000, 32'h40000000, r, lat, bok);
    check("six_by_two_q", r, 32'h40400000);
    check("six_by_two_lat", 32'(lat), 32'd28);
    check("six_by_two_busy", {31'b0, bok}, 32'd1);
    check("busy_low_at_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
    check("q_held", quotient, 32'h40400000);

    do_op(32'h3F800000, 32'h40400000, r, lat, bok);
    check("one_third", r, 32'h3EAAAAAA);
    do_op(32'hC1200000, 32'h40800000, r, lat, bok);
    check("neg_ten_by_four", r, 32'hC0200000);

    do_op(32'h3F800000, 32'h00000000, r, lat, bok);
    check("x_by_zero_q", r, 32'h7F800000);
    check("x_by_zero_lat", 32'(lat), 32'd3);
    do_op(32'h00000000, 32'h00000000, r, lat, bok);
    check("zero_by_zero_q", r, 32'h7FC00000);
    check("zero_by_zero_lat", 32'(lat), 32'd3);
    do_op(32'h80000000, 32'h40000000, r, lat, bok);
    check("negzero_by_two_q", r, 32'h80000000);
    check("negzero_by_two_lat", 32'(lat), 32'd3);

    do_op(32'h7F000000, 32'h00800000, r, lat, bok);
    check("overflow", r, 32'h7F800000);
    do_op(32'h00800000, 32'h7F000000, r, lat, bok);
    check("underflow", r, 32'h00000000);

    run_chk("inf_by_inf", 32'h7F800000, 32'hFF800000);
    run_chk("nan_in", 32'h3F800000, 32'h7FC12345);
    run_chk("inf_by_x", 32'hFF800000, 32'h40000000);
    run_chk("x_by_inf", 32'h40000000, 32'hFF800000);
    run_chk("denorm_div", 32'h00001234, 32'h40000000);

    // start pulse mid-operation must be ignored
    @(negedge clk);
    in1 = 32'h40C00000; in2 = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 9) begin @(negedge clk); lat++; end
    in1 = 32'h3F800000; in2 = 32'h40400000; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    check("ignored_start_q", quotient, 32'h40400000);
    check("ignored_start_lat", 32'(lat), 32'd28);

    // synchronous reset mid-operation
    @(negedge clk);
    in1 = 32'h41200000; in2 = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 14) begin @(negedge clk); lat++; end
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_q", quotient, 32'h0);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    run_chk("after_reset", 32'h3F800000, 32'h40400000);

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      b = $urandom;
      a[30:23] = 8'(100 + $urandom_range(0, 54));
      b[30:23] = 8'(100 + $urandom_range(0, 54));
      run_chk($sformatf("rnd_norm%0d", i), a, b);
    end
    for (int i = 0; i < 15; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b[30:23] = 8'hFF;
      if (i % 3 == 1) a[30:23] = 8'h00;
      run_chk($sformatf("rnd_any%0d", i), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
